mips_mc_ctrl: RTL and testbench

Parametrised multicycle controller for the MIPS core, the successor to the fixed 32-bit, zero-wait-state controller. It decodes `op`/`funct` and sequences fetch, decode, execute, memory and writeback through a Moore FSM. Memory accesses use a request/ready handshake, so the core tolerates wait-state memory. Width `N` selects MIPS32 or MIPS64 decode. It drives the existing datapath control signals unchanged, and adds `memreq`, `illegal` and `retire`.

---
 rtl/mips_pkg.sv | 73 +++++++
 rtl/mips_mc_ctrl_if.sv | 37 +++
 rtl/mips_aludec.sv | 36 +++
 rtl/mips_mc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and encodings for the MIPS multicycle controller.
// States, opcode/funct constants and datapath select codes.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_RTYPEEX, S_ALUWB, S_IMMEX, S_IMMWB,
        S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LBU  = 6'b100100;
    localparam logic [5:0] OP_LD   = 6'b110111;
    localparam logic [5:0] OP_SD   = 6'b111111;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] SRCB_B    = 3'b000;
    localparam logic [2:0] SRCB_INC  = 3'b001;
    localparam logic [2:0] SRCB_SEXT = 3'b010;
    localparam logic [2:0] SRCB_SHL  = 3'b011;
    localparam logic [2:0] SRCB_ZEXT = 3'b100;

    localparam logic [1:0] PC_ALU = 2'b00;
    localparam logic [1:0] PC_OUT = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [1:0] LB_FULL = 2'b00;
    localparam logic [1:0] LB_SB   = 2'b01;
    localparam logic [1:0] LB_UB   = 2'b10;

    // Registered Moore outputs; fetch/br/bne/jmp qualify the
    // combinational pcen/irwrite terms.
    typedef struct packed {
        logic       memreq;
        logic       memwr;
        logic       iord;
        logic       alusrca;
        logic [2:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluc;
        logic       regwrite;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] lb;
        logic       illegal;
        logic       fetch;
        logic       br;
        logic       bne;
        logic       jmp;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath/memory bundle.
// master = controller side, slave = datapath side.
interface mips_mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       memreq;
    logic       memwrite;
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [1:0] lb;
    logic       illegal;
    logic       retire;

    modport master (
        input  op, funct, zero, mem_ready,
        output memreq, memwrite, pcen, irwrite, regwrite,
        output iord, memtoreg, regdst, alusrca, alusrcb,
        output pcsrc, alucontrol, lb, illegal, retire
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  memreq, memwrite, pcen, irwrite, regwrite,
        input  iord, memtoreg, regdst, alusrca, alusrcb,
        input  pcsrc, alucontrol, lb, illegal, retire
    );
endinterface

// File: rtl/mips_aludec.sv
// ALU decoder: funct (R-type) or opcode to alucontrol.
// bad flags an R-type funct the ALU does not implement.
module mips_aludec
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       bad
);

    // Pick the ALU operation; unknown R-type funct is flagged.
    always_comb begin
        alucontrol = ALU_ADD;
        bad        = 1'b0;
        if (op == OP_R) begin
            case (funct)
                FN_ADD:  alucontrol = ALU_ADD;
                FN_SUB:  alucontrol = ALU_SUB;
                FN_AND:  alucontrol = ALU_AND;
                FN_OR:   alucontrol = ALU_OR;
                FN_SLT:  alucontrol = ALU_SLT;
                default: bad = 1'b1;
            endcase
        end else begin
            case (op)
                OP_ANDI:        alucontrol = ALU_AND;
                OP_ORI:         alucontrol = ALU_OR;
                OP_SLTI:        alucontrol = ALU_SLT;
                OP_BEQ, OP_BNE: alucontrol = ALU_SUB;
                default:        alucontrol = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS controller with wait-state memory handshake.
// Outputs are registered from the next state; only pcen/irwrite gate late.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            reset,
    mips_mc_ctrl_if.master  bus
);

    state_t     st;
    state_t     nx;
    ctrl_t      q;
    ctrl_t      d;
    logic [2:0] aluc;
    logic       fbad;
    logic       wide;
    logic       isst;
    logic [1:0] lbc;

    mips_aludec u_aludec (
        .op         (bus.op),
        .funct      (bus.funct),
        .alucontrol (aluc),
        .bad        (fbad)
    );

    assign wide = (N == 64);
    assign isst = (bus.op == OP_SW) || (wide && bus.op == OP_SD);
    assign lbc  = (bus.op == OP_LB)  ? LB_SB :
                  (bus.op == OP_LBU) ? LB_UB : LB_FULL;

    // Next-state sequencing, stalling on memory phases.
    always_comb begin
        nx = st;
        case (st)
            S_FETCH:   nx = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW, OP_LB, OP_LBU:       nx = S_MEMADR;
                    OP_LD, OP_SD:                      nx = wide ? S_MEMADR : S_HALT;
                    OP_R:                              nx = S_RTYPEEX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nx = S_IMMEX;
                    OP_BEQ, OP_BNE:                    nx = S_BRANCH;
                    OP_J:                              nx = S_JUMP;
                    default:                           nx = S_HALT;
                endcase
            end
            S_MEMADR:  nx = isst ? S_MEMWR : S_MEMRD;
            S_MEMRD:   nx = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   nx = S_FETCH;
            S_MEMWR:   nx = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: nx = fbad ? S_HALT : S_ALUWB;
            S_ALUWB:   nx = S_FETCH;
            S_IMMEX:   nx = S_IMMWB;
            S_IMMWB:   nx = S_FETCH;
            S_BRANCH:  nx = S_FETCH;
            S_JUMP:    nx = S_FETCH;
            S_HALT:    nx = S_HALT;
            default:   nx = S_FETCH;
        endcase
    end

    // Moore output decode for the state about to be entered.
    always_comb begin
        d      = '0;
        d.aluc = ALU_ADD;
        case (nx)
            S_FETCH: begin
                d.memreq  = 1'b1;
                d.alusrcb = SRCB_INC;
                d.fetch   = 1'b1;
            end
            S_DECODE:  d.alusrcb = SRCB_SHL;
            S_MEMADR: begin
                d.alusrca = 1'b1;
                d.alusrcb = SRCB_SEXT;
            end
            S_MEMRD: begin
                d.memreq = 1'b1;
                d.iord   = 1'b1;
                d.lb     = lbc;
            end
            S_MEMWB: begin
                d.regwrite = 1'b1;
                d.memtoreg = 1'b1;
                d.lb       = lbc;
            end
            S_MEMWR: begin
                d.memreq = 1'b1;
                d.memwr  = 1'b1;
                d.iord   = 1'b1;
            end
            S_RTYPEEX: begin
                d.alusrca = 1'b1;
                d.aluc    = aluc;
            end
            S_ALUWB: begin
                d.regwrite = 1'b1;
                d.regdst   = 1'b1;
            end
            S_IMMEX: begin
                d.alusrca = 1'b1;
                d.alusrcb = (bus.op == OP_ANDI || bus.op == OP_ORI)
                          ? SRCB_ZEXT : SRCB_SEXT;
                d.aluc    = aluc;
            end
            S_IMMWB:   d.regwrite = 1'b1;
            S_BRANCH: begin
                d.alusrca = 1'b1;
                d.aluc    = ALU_SUB;
                d.pcsrc   = PC_OUT;
                d.br      = 1'b1;
                d.bne     = (bus.op == OP_BNE);
            end
            S_JUMP: begin
                d.pcsrc = PC_JMP;
                d.jmp   = 1'b1;
            end
            S_HALT:    d.illegal = 1'b1;
            default:   d = d;
        endcase
    end

    // State and output register; reset lands in FETCH at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= S_FETCH;
            q         <= '0;
            q.memreq  <= 1'b1;
            q.alusrcb <= SRCB_INC;
            q.aluc    <= ALU_ADD;
            q.fetch   <= 1'b1;
        end else begin
            st <= nx;
            q  <= d;
        end
    end

    assign bus.memreq     = q.memreq;
    assign bus.memwrite   = q.memwr;
    assign bus.iord       = q.iord;
    assign bus.alusrca    = q.alusrca;
    assign bus.alusrcb    = q.alusrcb;
    assign bus.pcsrc      = q.pcsrc;
    assign bus.alucontrol = q.aluc;
    assign bus.regwrite   = q.regwrite;
    assign bus.memtoreg   = q.memtoreg;
    assign bus.regdst     = q.regdst;
    assign bus.lb         = q.lb;
    assign bus.illegal    = q.illegal;
    assign bus.irwrite    = q.fetch & bus.mem_ready & reset;
    assign bus.pcen       = bus.irwrite
                          | (q.br & (bus.zero ^ q.bne))
                          | q.jmp;
    assign bus.retire     = (st != S_FETCH) && (nx == S_FETCH);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized checker for mips_mc_ctrl at N=32 and N=64.
// Expected outputs come from a per-instruction phase model.
module tb_mips_mc_ctrl;

    typedef enum int {
        P_F, P_D, P_A, P_R, P_RW, P_W, P_X, P_XW, P_I, P_IW, P_B, P_J, P_H
    } phase_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op_v [2];
    logic [5:0] fn_v [2];
    logic       z_v  [2];
    logic       mr_v [2];
    logic [20:0] obs [2];
    int total = 0;
    int bad = 0;
    phase_t seq[$];

    mips_mc_ctrl_if b32 ();
    mips_mc_ctrl_if b64 ();

    mips_mc_ctrl #(.N(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    mips_mc_ctrl #(.N(64)) dut64 (.clk(clk), .reset(reset), .bus(b64));

    always #5 clk = ~clk;

    assign b32.op = op_v[0];
    assign b32.funct = fn_v[0];
    assign b32.zero = z_v[0];
    assign b32.mem_ready = mr_v[0];
    assign b64.op = op_v[1];
    assign b64.funct = fn_v[1];
    assign b64.zero = z_v[1];
    assign b64.mem_ready = mr_v[1];

    assign obs[0] = {b32.memreq, b32.memwrite, b32.pcen, b32.irwrite,
                     b32.regwrite, b32.iord, b32.memtoreg, b32.regdst,
                     b32.alusrca, b32.alusrcb, b32.pcsrc, b32.alucontrol,
                     b32.lb, b32.illegal, b32.retire};
    assign obs[1] = {b64.memreq, b64.memwrite, b64.pcen, b64.irwrite,
                     b64.regwrite, b64.iord, b64.memtoreg, b64.regdst,
                     b64.alusrca, b64.alusrcb, b64.pcsrc, b64.alucontrol,
                     b64.lb, b64.illegal, b64.retire};

    function automatic logic [2:0] rfn(logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic legal_fn(logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
               f == 6'b100101 || f == 6'b101010;
    endfunction

    function automatic logic [20:0] expv(phase_t p, logic [5:0] o,
            logic [5:0] f, logic mr, logic z, logic ret);
        logic mq = 0, mw = 0, pe = 0, ir = 0, rw = 0, io = 0;
        logic mt = 0, rd = 0, sa = 0, il = 0;
        logic [2:0] sb = 3'b000;
        logic [1:0] ps = 2'b00;
        logic [2:0] ac = 3'b010;
        logic [1:0] l = 2'b00;
        logic [1:0] lsel;
        lsel = (o == 6'b100000) ? 2'b01 : (o == 6'b100100) ? 2'b10 : 2'b00;
        case (p)
            P_F:  begin mq = 1; sb = 3'b001; pe = mr; ir = mr; end
            P_D:  sb = 3'b011;
            P_A:  begin sa = 1; sb = 3'b010; end
            P_R:  begin mq = 1; io = 1; l = lsel; end
            P_RW: begin rw = 1; mt = 1; l = lsel; end
            P_W:  begin mq = 1; mw = 1; io = 1; end
            P_X:  begin sa = 1; ac = rfn(f); end
            P_XW: begin rw = 1; rd = 1; end
            P_I: begin
                sa = 1;
                sb = (o == 6'b001100 || o == 6'b001101) ? 3'b100 : 3'b010;
                ac = (o == 6'b001100) ? 3'b000 :
                     (o == 6'b001101) ? 3'b001 :
                     (o == 6'b001010) ? 3'b111 : 3'b010;
            end
            P_IW: rw = 1;
            P_B: begin
                sa = 1; ac = 3'b110; ps = 2'b01;
                pe = (o == 6'b000101) ? ~z : z;
            end
            P_J:  begin ps = 2'b10; pe = 1; end
            P_H:  il = 1;
            default: il = 0;
        endcase
        return {mq, mw, pe, ir, rw, io, mt, rd, sa, sb, ps, ac, l, il, ret};
    endfunction

    task automatic build(input logic [5:0] o, input logic [5:0] f, input int w);
        seq = '{P_F, P_D};
        case (o)
            6'b100011, 6'b100000, 6'b100100: seq = {seq, P_A, P_R, P_RW};
            6'b101011: seq = {seq, P_A, P_W};
            6'b110111: seq = (w == 1) ? {seq, P_A, P_R, P_RW} : {seq, P_H};
            6'b111111: seq = (w == 1) ? {seq, P_A, P_W} : {seq, P_H};
            6'b000000: seq = legal_fn(f) ? {seq, P_X, P_XW} : {seq, P_X, P_H};
            6'b001000, 6'b001100, 6'b001101, 6'b001010: seq = {seq, P_I, P_IW};
            6'b000100, 6'b000101: seq.push_back(P_B);
            6'b000010: seq.push_back(P_J);
            default: seq.push_back(P_H);
        endcase
    endtask

    task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mr_v[0] = 1'b1;
        mr_v[1] = 1'b1;
        #1;
        chk("reset32", obs[0], expv(P_F, 6'b0, 6'b0, 1'b0, 1'b0, 1'b0));
        chk("reset64", obs[1], expv(P_F, 6'b0, 6'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        chk("rsthold32", obs[0], expv(P_F, 6'b0, 6'b0, 1'b0, 1'b0, 1'b0));
        chk("rsthold64", obs[1], expv(P_F, 6'b0, 6'b0, 1'b0, 1'b0, 1'b0));
        mr_v[0] = 1'b0;
        mr_v[1] = 1'b0;
        reset = 1'b1;
    endtask

    task automatic run(input int w, input logic [5:0] o, input logic [5:0] f,
            input logic z, input int fw, input int aw, input int abort);
        int i, wc, cyc, hc, lim;
        phase_t p;
        logic mr, wt, adv, ret;
        build(o, f, w);
        op_v[w] = o;
        fn_v[w] = f;
        z_v[w] = z;
        i = 0; wc = 0; cyc = 0; hc = 0;
        while (i < seq.size()) begin
            @(negedge clk);
            p = seq[i];
            wt = (p == P_F || p == P_R || p == P_W);
            if (wt) begin
                lim = (p == P_F) ? fw : aw;
                if (lim < 0) mr = ($urandom_range(0, 9) >= 3);
                else mr = (wc >= lim);
            end else begin
                mr = 1'($urandom_range(0, 1));
            end
            mr_v[w] = mr;
            adv = (p != P_H) && (!wt || mr);
            ret = adv && (i == seq.size() - 1);
            #1;
            cyc++;
            chk($sformatf("n%0d op=%b fn=%b ph=%0d cyc=%0d", w ? 64 : 32, o, f, p, cyc),
                obs[w], expv(p, o, f, mr, z, ret));
            if (abort > 0 && cyc == abort) return;
            if (p == P_H) begin
                hc++;
                if (hc == 3) break;
            end else if (adv) begin
                i++;
                wc = 0;
            end else begin
                wc++;
            end
        end
        @(negedge clk);
        mr_v[w] = 1'b0;
    endtask

    logic [5:0] opl [14];
    logic [5:0] fnl [5];

    initial begin
        opl = '{6'b100011, 6'b101011, 6'b100000, 6'b100100, 6'b110111,
                6'b111111, 6'b000000, 6'b001000, 6'b001100, 6'b001101,
                6'b001010, 6'b000100, 6'b000101, 6'b000010};
        fnl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int k = 0; k < 2; k++) begin
            op_v[k] = 6'b0; fn_v[k] = 6'b0; z_v[k] = 1'b0; mr_v[k] = 1'b0;
        end
        do_reset();
        run(0, 6'b000000, 6'b100000, 1'b0, 0, 0, 0);
        run(0, 6'b100011, 6'b000000, 1'b0, 2, 3, 0);
        run(0, 6'b000100, 6'b000000, 1'b1, 0, 0, 0);
        run(0, 6'b000101, 6'b000000, 1'b1, 0, 0, 0);
        run(0, 6'b000100, 6'b000000, 1'b0, 0, 0, 0);
        run(0, 6'b000101, 6'b000000, 1'b0, 1, 0, 0);
        run(0, 6'b000010, 6'b000000, 1'b0, 0, 0, 0);
        run(0, 6'b001100, 6'b000000, 1'b0, 0, 0, 0);
        run(0, 6'b100100, 6'b000000, 1'b0, 0, 2, 0);
        run(0, 6'b100000, 6'b000000, 1'b0, 0, 0, 0);
        run(0, 6'b101011, 6'b000000, 1'b0, 1, 2, 0);
        run(0, 6'b001101, 6'b000000, 1'b0, 0, 0, 0);
        run(0, 6'b001010, 6'b000000, 1'b0, 0, 0, 0);
        run(0, 6'b000000, 6'b101010, 1'b0, 0, 0, 0);
        run(0, 6'b110111, 6'b000000, 1'b0, 0, 0, 0);
        run(1, 6'b110111, 6'b000000, 1'b0, 0, 1, 0);
        run(1, 6'b111111, 6'b000000, 1'b0, 0, 0, 0);
        do_reset();
        run(1, 6'b000000, 6'b000111, 1'b0, 0, 0, 0);
        run(0, 6'b101011, 6'b000000, 1'b0, 0, 5, 5);
        #1;
        reset = 1'b0;
        #1;
        chk("midstall32", obs[0], expv(P_F, 6'b0, 6'b0, 1'b0, 1'b0, 1'b0));
        chk("clrill64", obs[1], expv(P_F, 6'b0, 6'b0, 1'b0, 1'b0, 1'b0));
        mr_v[0] = 1'b0;
        mr_v[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 300; k++) begin
            int w, idx;
            logic [5:0] o, f;
            w = k % 2;
            idx = $urandom_range(0, 15);
            o = (idx < 14) ? opl[idx] : 6'($urandom);
            f = ($urandom_range(0, 9) < 8) ? fnl[$urandom_range(0, 4)] : 6'($urandom);
            run(w, o, f, 1'($urandom_range(0, 1)), -1, -1, 0);
            if (seq[seq.size() - 1] == P_H) do_reset();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
